// File: rtl/icache_pkg.sv
//------------------------------------------------------------------------------
// icache_pkg
// Shared widths and FSM state encoding for the instruction cache.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package icache_pkg;

    localparam int ADDRESS_WIDTH      = 32;
    localparam int ID_WIDTH           = 32;
    localparam int ICACHE_INDEX_WIDTH = 8;

    typedef enum logic [0:0] {
        ICACHE_IDLE = 1'b0,
        ICACHE_WAIT = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_line_array.sv
//------------------------------------------------------------------------------
// icache_line_array
// Valid/tag/data storage for the direct-mapped icache: one combinational read
// port, one synchronous write port, valid bits cleared synchronously on reset.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icache_line_array #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 22,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag_ram  [LINES];
    logic [DATA_WIDTH-1:0] r_data_ram [LINES];

    // Valid bits: cleared by reset, set when a line is filled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage need no reset; valid gates their use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag_ram[wr_index]  <= wr_tag;
            r_data_ram[wr_index] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag_ram[rd_index];
    assign rd_data  = r_data_ram[rd_index];

endmodule

`default_nettype wire

// File: rtl/icache.sv
//------------------------------------------------------------------------------
// icache
// Direct-mapped, read-only instruction cache, one 32-bit word per line.
// Combinational lookup, single outstanding fill to the memory controller.
// Optional feature macro: ICACHE_PERF_CNT_EN adds hit/miss counter ports.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = ADDRESS_WIDTH,
    parameter int DATA_WIDTH  = ID_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [ADDR_WIDTH-1:0] if_icache_inst_addr_in,
    output logic                  icache_if_miss_out,
    output logic [DATA_WIDTH-1:0] icache_if_inst_inst_out,
    output logic                  icache_memctrl_en_out,
    output logic [ADDR_WIDTH-1:0] icache_memctrl_addr_out,
    input  logic                  memctrl_icache_rdy_in,
    input  logic [DATA_WIDTH-1:0] memctrl_icache_inst_in
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           icache_hit_cnt_out,
    output logic [31:0]           icache_miss_cnt_out
`endif
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

    icache_state_t          r_state;
    logic [TAG_WIDTH-1:0]   r_fill_tag;
    logic [INDEX_WIDTH-1:0] r_fill_index;

    logic [TAG_WIDTH-1:0]   w_tag;
    logic [INDEX_WIDTH-1:0] w_index;
    logic                   w_line_valid;
    logic [TAG_WIDTH-1:0]   w_line_tag;
    logic                   w_hit;
    logic                   w_fill_wr;
    logic [1:0]             w_unused_byte_offset;

    assign w_tag                = if_icache_inst_addr_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign w_index              = if_icache_inst_addr_in[INDEX_WIDTH+1:2];
    assign w_unused_byte_offset = if_icache_inst_addr_in[1:0];

    assign w_hit              = w_line_valid && (w_line_tag == w_tag);
    assign icache_if_miss_out = !w_hit;

    // The response only lands while waiting and unfrozen; a late pulse after reset is dropped
    assign w_fill_wr = (r_state == ICACHE_WAIT) && memctrl_icache_rdy_in && rdy_in && !rst_in;

    icache_line_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_line_array (
        .clk      (clk_in),
        .rst      (rst_in),
        .rd_index (w_index),
        .rd_valid (w_line_valid),
        .rd_tag   (w_line_tag),
        .rd_data  (icache_if_inst_inst_out),
        .wr_en    (w_fill_wr),
        .wr_index (r_fill_index),
        .wr_tag   (r_fill_tag),
        .wr_data  (memctrl_icache_inst_in)
    );

    // Fill FSM: request on an IDLE miss, hold the request until the response pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state                 <= ICACHE_IDLE;
            icache_memctrl_en_out   <= 1'b0;
            icache_memctrl_addr_out <= '0;
            r_fill_tag              <= '0;
            r_fill_index            <= '0;
        end else if (rdy_in) begin
            case (r_state)
                ICACHE_IDLE: begin
                    if (!w_hit) begin
                        icache_memctrl_en_out   <= 1'b1;
                        icache_memctrl_addr_out <= {if_icache_inst_addr_in[ADDR_WIDTH-1:2], 2'b00};
                        r_fill_tag              <= w_tag;
                        r_fill_index            <= w_index;
                        r_state                 <= ICACHE_WAIT;
                    end
                end
                ICACHE_WAIT: begin
                    if (memctrl_icache_rdy_in) begin
                        icache_memctrl_en_out <= 1'b0;
                        r_state               <= ICACHE_IDLE;
                    end
                end
                default: r_state <= ICACHE_IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Hit counts every unfrozen cycle the fetch stage receives data; miss counts fills started
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            icache_hit_cnt_out  <= '0;
            icache_miss_cnt_out <= '0;
        end else if (rdy_in) begin
            if (w_hit) begin
                icache_hit_cnt_out <= icache_hit_cnt_out + 32'd1;
            end
            if ((r_state == ICACHE_IDLE) && !w_hit) begin
                icache_miss_cnt_out <= icache_miss_cnt_out + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration; lookup and fill behave identically.
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
//------------------------------------------------------------------------------
// tb_icache
// Directed self-checking bench for icache (default INDEX_WIDTH = 8).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] fetch_addr;
    logic        miss;
    logic [31:0] inst;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_inst;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_vec;
    int n_miscompare;

    icache u_dut (
        .clk_in                  (clk),
        .rst_in                  (rst),
        .rdy_in                  (rdy),
        .if_icache_inst_addr_in  (fetch_addr),
        .icache_if_miss_out      (miss),
        .icache_if_inst_inst_out (inst),
        .icache_memctrl_en_out   (mem_en),
        .icache_memctrl_addr_out (mem_addr),
        .memctrl_icache_rdy_in   (mem_rdy),
        .memctrl_icache_inst_in  (mem_inst)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .icache_hit_cnt_out      (hit_cnt),
        .icache_miss_cnt_out     (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; drives and checks happen 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cold miss on a, request appears next cycle, respond with d after dly cycles, then hit
    task automatic fill(input logic [31:0] a, input logic [31:0] d, input int dly);
        fetch_addr = a;
        #1;
        check_vec("fill_miss", {31'd0, miss}, 32'd1);
        tick();
        check_vec("fill_en", {31'd0, mem_en}, 32'd1);
        check_vec("fill_addr", mem_addr, {a[31:2], 2'b00});
        for (int i = 0; i < dly; i++) begin
            tick();
            check_vec("fill_en_held", {31'd0, mem_en}, 32'd1);
        end
        mem_rdy  = 1'b1;
        mem_inst = d;
        tick();
        mem_rdy = 1'b0;
        #1;
        check_vec("fill_hit", {31'd0, miss}, 32'd0);
        check_vec("fill_data", inst, d);
        check_vec("fill_en_drop", {31'd0, mem_en}, 32'd0);
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        rst          = 1'b1;
        rdy          = 1'b1;
        fetch_addr   = 32'h0000_0100;
        mem_rdy      = 1'b0;
        mem_inst     = 32'h0;
        tick();
        tick();
        check_vec("rst_en", {31'd0, mem_en}, 32'd0);
        check_vec("rst_addr", mem_addr, 32'h0);
        check_vec("rst_miss", {31'd0, miss}, 32'd1);
        rst = 1'b0;

        // Basic cold miss with a 5-cycle response delay
        fill(32'h0000_0100, 32'h0000_0013, 5);

        // Same index, different tag: evicts 0x100, then 0x100 misses again
        fill(32'h0000_0500, 32'hAAAA_0001, 2);
        fill(32'h0000_0100, 32'h0000_0013, 1);
        fetch_addr = 32'h0000_0500;
        #1;
        check_vec("evicted_500", {31'd0, miss}, 32'd1);
        fetch_addr = 32'h0000_0100;
        #1;

        // Hit-under-miss: 0x200 fill outstanding while fetch reads cached 0x100
        fetch_addr = 32'h0000_0200;
        tick();
        check_vec("hum_en", {31'd0, mem_en}, 32'd1);
        fetch_addr = 32'h0000_0100;
        #1;
        check_vec("hum_miss", {31'd0, miss}, 32'd0);
        check_vec("hum_data", inst, 32'h0000_0013);
        tick();
        check_vec("hum_en_held", {31'd0, mem_en}, 32'd1);
        check_vec("hum_addr_held", mem_addr, 32'h0000_0200);
        mem_rdy  = 1'b1;
        mem_inst = 32'h1234_5678;
        tick();
        mem_rdy = 1'b0;
        check_vec("hum_en_drop", {31'd0, mem_en}, 32'd0);
        fetch_addr = 32'h0000_0200;
        #1;
        check_vec("hum_fill_hit", {31'd0, miss}, 32'd0);
        check_vec("hum_fill_data", inst, 32'h1234_5678);

        // Global ready low for 3 cycles while the response pulse is held
        fetch_addr = 32'h0000_0300;
        tick();
        check_vec("frz_en", {31'd0, mem_en}, 32'd1);
        rdy      = 1'b0;
        mem_rdy  = 1'b1;
        mem_inst = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("frz_en_held", {31'd0, mem_en}, 32'd1);
            check_vec("frz_miss", {31'd0, miss}, 32'd1);
        end
        rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        #1;
        check_vec("frz_en_drop", {31'd0, mem_en}, 32'd0);
        check_vec("frz_hit", {31'd0, miss}, 32'd0);
        check_vec("frz_data", inst, 32'h0BAD_F00D);

        // Reset during WAIT: request dropped, lines invalid, stray pulse ignored
        fetch_addr = 32'h0000_0400;
        tick();
        check_vec("rw_en", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        tick();
        check_vec("rw_en_clr", {31'd0, mem_en}, 32'd0);
        check_vec("rw_addr_clr", mem_addr, 32'h0);
        rst        = 1'b0;
        fetch_addr = 32'h0000_0100;
        mem_rdy    = 1'b1;
        mem_inst   = 32'hDEAD_BEEF;
        #1;
        check_vec("rw_invalid_100", {31'd0, miss}, 32'd1);
        tick();
        mem_rdy = 1'b0;
        #1;
        check_vec("rw_stray_miss", {31'd0, miss}, 32'd1);
        check_vec("rw_new_en", {31'd0, mem_en}, 32'd1);
        check_vec("rw_new_addr", mem_addr, 32'h0000_0100);
        fetch_addr = 32'h0000_0400;
        #1;
        check_vec("rw_invalid_400", {31'd0, miss}, 32'd1);
        fetch_addr = 32'h0000_0200;
        #1;
        check_vec("rw_invalid_200", {31'd0, miss}, 32'd1);

`ifdef ICACHE_PERF_CNT_EN
        // Two cold misses then three hit cycles
        rst = 1'b1;
        tick();
        check_vec("cnt_rst_hit", hit_cnt, 32'd0);
        check_vec("cnt_rst_miss", miss_cnt, 32'd0);
        rst = 1'b0;
        fill(32'h0000_0100, 32'h0000_0013, 1);
        fill(32'h0000_0200, 32'h1234_5678, 1);
        tick();
        fetch_addr = 32'h0000_0100;
        tick();
        tick();
        check_vec("cnt_hit", hit_cnt, 32'd3);
        check_vec("cnt_miss", miss_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

`default_nettype wire
